// File: rtl/alu_seq_if.sv
// Issue/result handshake bundle between register-file read, the sequential ALU and writeback.
// The master side issues operations and consumes results; the slave side is the ALU.
interface alu_seq_if #(
  parameter int WIDTH = 16
) ();
  logic             in_valid;
  logic             in_ready;
  logic [7:0]       opcode;
  logic [WIDTH-1:0] r1;
  logic [WIDTH-1:0] r2;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] rout;
  logic [WIDTH-1:0] rout_hi;
  logic             out_err;
  logic [4:0]       flags;
  logic             busy;

  modport master (
    output in_valid, opcode, r1, r2, out_ready,
    input  in_ready, out_valid, rout, rout_hi, out_err, flags, busy
  );

  modport slave (
    input  in_valid, opcode, r1, r2, out_ready,
    output in_ready, out_valid, rout, rout_hi, out_err, flags, busy
  );
endinterface

// File: rtl/alu_seq.sv
// Registered ALU with a persistent {N,Z,F,L,C} flag register, valid/ready on both sides
// and a shift-add multiplier that retires one multiplier bit per cycle.
module alu_seq #(
  parameter int WIDTH  = 16,
  parameter bit MUL_EN = 1'b1
) (
  input logic    clk,
  input logic    reset,
  alu_seq_if.slave bus
);
  localparam int CW = $clog2(WIDTH);
  localparam int M  = WIDTH - 1;
  localparam logic [WIDTH-1:0] WIDTH_V   = WIDTH'(WIDTH);
  localparam logic [CW-1:0]    LAST_ITER = CW'(WIDTH - 1);

  localparam int FC = 0;
  localparam int FL = 1;
  localparam int FF = 2;
  localparam int FZ = 3;
  localparam int FN = 4;

  localparam logic [7:0] OP_AND  = 8'h01;
  localparam logic [7:0] OP_OR   = 8'h02;
  localparam logic [7:0] OP_XOR  = 8'h03;
  localparam logic [7:0] OP_NOT  = 8'h04;
  localparam logic [7:0] OP_ADD  = 8'h05;
  localparam logic [7:0] OP_ADDU = 8'h06;
  localparam logic [7:0] OP_ADDC = 8'h07;
  localparam logic [7:0] OP_RSH  = 8'h08;
  localparam logic [7:0] OP_SUB  = 8'h09;
  localparam logic [7:0] OP_SUBC = 8'h0A;
  localparam logic [7:0] OP_CMP  = 8'h0B;
  localparam logic [7:0] OP_ALSH = 8'h0C;
  localparam logic [7:0] OP_MUL  = 8'h0E;
  localparam logic [7:0] OP_ARSH = 8'h0F;
  localparam logic [7:0] OP_LSH  = 8'h84;

  typedef enum logic {S_IDLE, S_MUL} state_t;

  state_t           state;
  logic [WIDTH-1:0] rout_q, rout_hi_q;
  logic             err_q, valid_q;
  logic [4:0]       flags_q;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] mcand, prod_hi, prod_lo;

  logic [WIDTH-1:0] a, b, addend, res;
  logic [WIDTH:0]   sum;
  logic             cin, ovf, err, is_mul, shift_big, in_ready, accept;
  logic [4:0]       nf;
  logic [WIDTH:0]   mul_add;
  logic [WIDTH-1:0] mul_next_hi, mul_next_lo;

  assign a = bus.r1;
  assign b = bus.r2;

  assign in_ready = (state == S_IDLE) && (!valid_q || bus.out_ready);
  assign accept   = bus.in_valid && in_ready;

  // Subtraction-class ops share the adder as r1 + ~r2 + cin; ovf covers both add and sub.
  always_comb begin
    addend = b;
    cin    = 1'b0;
    case (bus.opcode)
      OP_ADDC:        cin = flags_q[FC];
      OP_SUB, OP_CMP: begin addend = ~b; cin = 1'b1; end
      OP_SUBC:        begin addend = ~b; cin = flags_q[FC]; end
      default:        ;
    endcase
  end

  assign sum       = {1'b0, a} + {1'b0, addend} + {{WIDTH{1'b0}}, cin};
  assign ovf       = (a[M] == addend[M]) && (sum[M] != a[M]);
  assign shift_big = (a >= WIDTH_V);

  always_comb begin
    res    = '0;
    err    = 1'b0;
    is_mul = 1'b0;
    nf     = flags_q;
    case (bus.opcode)
      OP_ADD, OP_ADDC, OP_SUB, OP_SUBC: begin
        res    = sum[WIDTH-1:0];
        nf[FC] = sum[WIDTH];
        nf[FF] = ovf;
      end
      OP_ADDU: begin
        res    = sum[WIDTH-1:0];
        nf[FC] = sum[WIDTH];
      end
      OP_CMP: begin
        res    = sum[WIDTH-1:0];
        nf[FZ] = (a == b);
        nf[FL] = (a < b);
        nf[FN] = ($signed(a) < $signed(b));
      end
      OP_AND:          res = a & b;
      OP_OR:           res = a | b;
      OP_XOR:          res = a ^ b;
      OP_NOT:          res = ~a;
      OP_LSH, OP_ALSH: res = shift_big ? '0 : (b << a);
      OP_RSH:          res = shift_big ? '0 : (b >> a);
      OP_ARSH:         res = shift_big ? {WIDTH{b[M]}} : $unsigned($signed(b) >>> a);
      OP_MUL: begin
        if (MUL_EN) is_mul = 1'b1;
        else        err    = 1'b1;
      end
      default:         err = 1'b1;
    endcase
    if (!err && !is_mul && bus.opcode != OP_CMP) begin
      nf[FZ] = (res == '0);
      nf[FN] = res[M];
    end
  end

  // One shift-add step: conditionally add the multiplicand into the high half, then shift the pair right.
  always_comb begin
    mul_add     = {1'b0, prod_hi} + (prod_lo[0] ? {1'b0, mcand} : '0);
    mul_next_hi = mul_add[WIDTH:1];
    mul_next_lo = {mul_add[0], prod_lo[WIDTH-1:1]};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      rout_q    <= '0;
      rout_hi_q <= '0;
      err_q     <= 1'b0;
      valid_q   <= 1'b0;
      flags_q   <= '0;
      cnt       <= '0;
      mcand     <= '0;
      prod_hi   <= '0;
      prod_lo   <= '0;
    end else begin
      if (valid_q && bus.out_ready) valid_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (accept) begin
            if (is_mul) begin
              mcand   <= a;
              prod_hi <= '0;
              prod_lo <= b;
              cnt     <= '0;
              state   <= S_MUL;
            end else begin
              rout_q    <= res;
              rout_hi_q <= '0;
              err_q     <= err;
              flags_q   <= nf;
              valid_q   <= 1'b1;
            end
          end
        end
        S_MUL: begin
          prod_hi <= mul_next_hi;
          prod_lo <= mul_next_lo;
          cnt     <= cnt + CW'(1);
          if (cnt == LAST_ITER) begin
            rout_q      <= mul_next_lo;
            rout_hi_q   <= mul_next_hi;
            err_q       <= 1'b0;
            flags_q[FC] <= |mul_next_hi;
            flags_q[FZ] <= ~|mul_next_lo;
            flags_q[FN] <= mul_next_lo[M];
            valid_q     <= 1'b1;
            cnt         <= '0;
            state       <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = valid_q;
  assign bus.rout      = rout_q;
  assign bus.rout_hi   = rout_hi_q;
  assign bus.out_err   = err_q;
  assign bus.flags     = flags_q;
  assign bus.busy      = (state == S_MUL);
endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq at WIDTH=16: hand-computed results, flags, latency and handshake behaviour.
// Flags are compared as the 5-bit {N,Z,F,L,C} vector.
module tb_alu_seq;
  logic clk;
  logic reset;
  int   checks;
  int   errors;
  int   cycles;

  alu_seq_if #(.WIDTH(16)) bus ();

  alu_seq #(.WIDTH(16), .MUL_EN(1'b1)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [7:0] op, input logic [15:0] x, input logic [15:0] y);
    bus.in_valid = 1'b1;
    bus.opcode   = op;
    bus.r1       = x;
    bus.r2       = y;
  endtask

  // Presents one operation for exactly one clock edge; caller guarantees in_ready.
  task automatic apply_stimulus(input logic [7:0] op, input logic [15:0] x, input logic [15:0] y);
    drive(op, x, y);
    step();
    bus.in_valid = 1'b0;
  endtask

  task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  initial begin
    checks        = 0;
    errors        = 0;
    reset         = 1'b1;
    bus.in_valid  = 1'b0;
    bus.opcode    = 8'h00;
    bus.r1        = 16'h0000;
    bus.r2        = 16'h0000;
    bus.out_ready = 1'b1;

    step();
    step();
    check_output("rst_out_valid", 32'(bus.out_valid), 32'h0);
    check_output("rst_rout",      32'(bus.rout),      32'h0);
    check_output("rst_rout_hi",   32'(bus.rout_hi),   32'h0);
    check_output("rst_out_err",   32'(bus.out_err),   32'h0);
    check_output("rst_flags",     32'(bus.flags),     32'h0);
    check_output("rst_busy",      32'(bus.busy),      32'h0);
    reset = 1'b0;
    #1;
    check_output("rst_in_ready",  32'(bus.in_ready),  32'h1);
    $display("[TB] reset released");

    // Signed overflow into the sign bit, single-cycle latency
    check_output("add_pre_valid", 32'(bus.out_valid), 32'h0);
    apply_stimulus(8'h05, 16'h7FFF, 16'h0001);
    check_output("add_ovf_valid", 32'(bus.out_valid), 32'h1);
    check_output("add_ovf_rout",  32'(bus.rout),      32'h8000);
    check_output("add_ovf_flags", 32'(bus.flags),     32'b10100);

    // Carry out, then ADDC consumes it back-to-back
    apply_stimulus(8'h05, 16'hFFFF, 16'h0001);
    check_output("add_carry_rout",  32'(bus.rout),  32'h0000);
    check_output("add_carry_flags", 32'(bus.flags), 32'b01001);
    apply_stimulus(8'h07, 16'h0001, 16'h0001);
    check_output("addc_rout",  32'(bus.rout),  32'h0003);
    check_output("addc_flags", 32'(bus.flags), 32'b00000);

    apply_stimulus(8'h0B, 16'h0003, 16'h0005);
    check_output("cmp_lt_rout",  32'(bus.rout),  32'hFFFE);
    check_output("cmp_lt_flags", 32'(bus.flags), 32'b10010);
    apply_stimulus(8'h0B, 16'h8000, 16'h0001);
    check_output("cmp_sgn_flags", 32'(bus.flags), 32'b10000);
    apply_stimulus(8'h0B, 16'h1234, 16'h1234);
    check_output("cmp_eq_flags", 32'(bus.flags), 32'b01000);

    // Multiply: result exactly WIDTH edges after the accept edge
    apply_stimulus(8'h0E, 16'h1234, 16'h0100);
    check_output("mul_busy",      32'(bus.busy),      32'h1);
    check_output("mul_in_ready",  32'(bus.in_ready),  32'h0);
    check_output("mul_out_valid", 32'(bus.out_valid), 32'h0);
    cycles = 0;
    while (!bus.out_valid && cycles < 40) begin
      step();
      cycles++;
    end
    check_output("mul_latency", 32'(cycles),        32'd16);
    check_output("mul_rout",    32'(bus.rout),      32'h3400);
    check_output("mul_rout_hi", 32'(bus.rout_hi),   32'h0012);
    check_output("mul_flags",   32'(bus.flags),     32'b00001);
    check_output("mul_done_busy",  32'(bus.busy),     32'h0);
    check_output("mul_done_ready", 32'(bus.in_ready), 32'h1);

    // Back-pressure: result held while out_ready is low, drain and accept on the same edge
    apply_stimulus(8'h05, 16'h0001, 16'h0002);
    check_output("hold_first_rout", 32'(bus.rout),    32'h0003);
    check_output("hold_first_hi",   32'(bus.rout_hi), 32'h0000);
    bus.out_ready = 1'b0;
    step();
    step();
    step();
    check_output("hold_valid",    32'(bus.out_valid), 32'h1);
    check_output("hold_rout",     32'(bus.rout),      32'h0003);
    check_output("hold_in_ready", 32'(bus.in_ready),  32'h0);
    drive(8'h05, 16'h0010, 16'h0020);
    bus.out_ready = 1'b1;
    #1;
    check_output("drain_in_ready", 32'(bus.in_ready), 32'h1);
    step();
    bus.in_valid = 1'b0;
    check_output("drain_new_valid", 32'(bus.out_valid), 32'h1);
    check_output("drain_new_rout",  32'(bus.rout),      32'h0030);

    // Shifts, including amounts at or beyond the width
    apply_stimulus(8'h0F, 16'd20, 16'h8000);
    check_output("arsh_rout",  32'(bus.rout),  32'hFFFF);
    check_output("arsh_flags", 32'(bus.flags), 32'b10000);
    apply_stimulus(8'h08, 16'd15, 16'h8000);
    check_output("rsh_rout", 32'(bus.rout), 32'h0001);
    apply_stimulus(8'h0C, 16'd4, 16'h00F0);
    check_output("alsh_rout", 32'(bus.rout), 32'h0F00);
    apply_stimulus(8'h84, 16'd16, 16'h0001);
    check_output("lsh_rout",  32'(bus.rout),  32'h0000);
    check_output("lsh_flags", 32'(bus.flags), 32'b01000);

    apply_stimulus(8'h09, 16'h0005, 16'h0007);
    check_output("sub_borrow_rout",  32'(bus.rout),  32'hFFFE);
    check_output("sub_borrow_flags", 32'(bus.flags), 32'b10000);

    // Illegal opcode leaves flags alone
    apply_stimulus(8'hFF, 16'h1111, 16'h2222);
    check_output("illegal_valid", 32'(bus.out_valid), 32'h1);
    check_output("illegal_err",   32'(bus.out_err),   32'h1);
    check_output("illegal_rout",  32'(bus.rout),      32'h0000);
    check_output("illegal_flags", 32'(bus.flags),     32'b10000);

    apply_stimulus(8'h01, 16'h0F0F, 16'h00FF);
    check_output("and_err",   32'(bus.out_err), 32'h0);
    check_output("and_rout",  32'(bus.rout),    32'h000F);
    check_output("and_flags", 32'(bus.flags),   32'b00000);

    apply_stimulus(8'h09, 16'h8000, 16'h0001);
    check_output("sub_ovf_rout",  32'(bus.rout),  32'h7FFF);
    check_output("sub_ovf_flags", 32'(bus.flags), 32'b00101);

    // Asynchronous reset in the middle of a multiply
    apply_stimulus(8'h0E, 16'hFFFF, 16'hFFFF);
    step();
    step();
    step();
    check_output("mid_mul_busy", 32'(bus.busy), 32'h1);
    reset = 1'b1;
    #1;
    check_output("mulrst_busy",    32'(bus.busy),      32'h0);
    check_output("mulrst_valid",   32'(bus.out_valid), 32'h0);
    check_output("mulrst_rout",    32'(bus.rout),      32'h0);
    check_output("mulrst_rout_hi", 32'(bus.rout_hi),   32'h0);
    check_output("mulrst_err",     32'(bus.out_err),   32'h0);
    check_output("mulrst_flags",   32'(bus.flags),     32'h0);
    step();
    reset = 1'b0;
    #1;
    check_output("mulrst_in_ready", 32'(bus.in_ready), 32'h1);
    step();
    check_output("mulrst_no_result", 32'(bus.out_valid), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
